// File: rtl/progmem_bus_pkg.sv
// progmem_bus_pkg: shared state, default and PicoRV32 valid/ready bus types for program-memory arbitration
package progmem_bus_pkg;
  localparam int PM_ADDR_W = 32;
  localparam int PM_DATA_W = 32;
  localparam logic [PM_DATA_W-1:0] PM_ERR_WORD = 32'hDEAD_BEEF;
  typedef enum logic {IDLE, BUSY} state_e;
  typedef struct packed {
    logic                 valid;
    logic [PM_ADDR_W-1:0] addr;
  } pmem_req_t;
  typedef struct packed {
    logic                 ready;
    logic [PM_DATA_W-1:0] rdata;
  } pmem_rsp_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; on a tie the requester not granted last wins
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o
);
  logic last_q;
  assign gnt_o = &req_i ? ~last_q : req_i[1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last_q <= 1'b1;
    else if (en_i) last_q <= gnt_o;
endmodule

// File: rtl/progmem_arbiter.sv
// progmem_arbiter: shares the program-memory port between two requesters with a bus-timeout watchdog
module progmem_arbiter
  import progmem_bus_pkg::*;
#(
  parameter int                 ADDR_W   = PM_ADDR_W,
  parameter int                 DATA_W   = PM_DATA_W,
  parameter int                 TIMEOUT  = 16,
  parameter logic [DATA_W-1:0]  ERR_WORD = PM_ERR_WORD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);
  state_e            state_q;
  logic              gnt_q, err_q, arb_gnt, busy, start, g_valid, done, tmo, abort, fin;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic [DATA_W-1:0] rdata;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req_i ({m1_valid, m0_valid}),
    .en_i  (start),
    .gnt_o (arb_gnt)
  );
  assign busy    = state_q == BUSY;
  assign start   = !busy && (m0_valid || m1_valid);
  assign g_valid = gnt_q ? m1_valid : m0_valid;
  assign done    = busy && s_ready;
  // a requester that withdrew its request gets neither data nor a timeout pulse
  assign abort   = busy && !s_ready && !g_valid;
  assign tmo     = busy && !s_ready && g_valid && cnt_q == 8'(TIMEOUT - 1);
  assign fin     = done || tmo || abort;
  assign rdata   = done ? s_rdata : ERR_WORD;
  assign m0_ready = (done || tmo) && !gnt_q;
  assign m1_ready = (done || tmo) && gnt_q;
  assign m0_rdata = m0_ready ? rdata : '0;
  assign m1_rdata = m1_ready ? rdata : '0;
  assign s_valid  = busy;
  assign s_addr   = addr_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (start) begin
        state_q <= BUSY;
        gnt_q   <= arb_gnt;
        addr_q  <= arb_gnt ? m1_addr : m0_addr;
      end else if (fin) state_q <= IDLE;
      cnt_q <= busy && !fin ? cnt_q + 8'd1 : '0;
      // a timeout coinciding with a clear still records the new address
      if (tmo) begin
        err_q <= 1'b1;
        if (!err_q || err_clr) err_addr_q <= addr_q;
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
endmodule

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: vector table, directed corner sequences and a randomized run against a transaction model
module tb_progmem_arbiter;
  import progmem_bus_pkg::*;
  localparam int TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0, rstn;
  logic m0_valid, m1_valid, m0_ready, m1_ready, s_valid, s_ready, err, err_clr;
  logic [31:0] m0_addr, m1_addr, m0_rdata, m1_rdata, s_addr, s_rdata, err_addr;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  progmem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
    .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );
  typedef struct packed {
    logic v0; logic [31:0] a0; logic v1; logic [31:0] a1; logic sr; logic [31:0] sd;
    logic sv; logic [31:0] sa; logic r0; logic [31:0] d0; logic r1; logic [31:0] d1;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic chk1(input string n, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rstn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = '0; m1_addr = '0;
    s_ready = 1'b0; s_rdata = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  // one request held for TMO cycles; the slave answers only in the final cycle when rdy is set
  task automatic run_tmo(input logic who, input logic [31:0] a, input logic clr, input logic rdy,
                         input logic exp_err, input logic [31:0] exp_ea);
    tick();
    if (who) begin m1_valid = 1'b1; m1_addr = a; end
    else begin m0_valid = 1'b1; m0_addr = a; end
    s_ready = 1'b0;
    #2 chk1("tmo_start_sv", s_valid, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      if (i == TMO) begin s_ready = rdy; s_rdata = 32'hCAFE_0001; err_clr = clr; end
      #2;
      chk1("tmo_ready", who ? m1_ready : m0_ready, i == TMO);
      chk1("tmo_other_ready", who ? m0_ready : m1_ready, 1'b0);
      if (i == TMO) chk("tmo_rdata", who ? m1_rdata : m0_rdata, rdy ? 32'hCAFE_0001 : ERR);
    end
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
    #2;
    chk1("tmo_idle_sv", s_valid, 1'b0);
    chk1("tmo_err", err, exp_err);
    chk("tmo_err_addr", err_addr, exp_ea);
  endtask
  logic       sv_p, sr_p, got, m_busy, m_own, m_last, m_err, gv, fin, tmo;
  logic [1:0] pend, prev_r, e_r;
  logic [31:0] pa [2];
  logic [31:0] m_addr, m_eaddr, e_d, fexp;
  int         m_wait;
  initial begin
    tbl[0]  = '{1'b1, 32'h0010_0004, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0010_0004, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0010_0004, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'h0010_0004, 1'b0, 32'h0, 1'b1, 32'h0100_0537, 1'b1, 32'h0010_0004, 1'b1, 32'h0100_0537, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b1, 32'h200,       1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h200,       1'b1, 32'h300, 1'b0, 32'h0,       1'b1, 32'h200,       1'b0, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h200,       1'b1, 32'h300, 1'b0, 32'h0,       1'b1, 32'h200,       1'b0, 32'h0,         1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'h300, 1'b0, 32'h0,       1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 32'h300, 1'b0, 32'h0,       1'b1, 32'h300,       1'b0, 32'h0,         1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 32'h300, 1'b1, 32'h1234_5678, 1'b1, 32'h300,     1'b0, 32'h0,         1'b1, 32'h1234_5678};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    do_reset();
    #1;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    // single read, IDLE gating of s_ready, abort followed by the pending requester
    foreach (tbl[i]) begin
      tick();
      m0_valid = tbl[i].v0; m0_addr = tbl[i].a0; m1_valid = tbl[i].v1; m1_addr = tbl[i].a1;
      s_ready = tbl[i].sr; s_rdata = tbl[i].sd;
      #2;
      chk1($sformatf("vec%0d_s_valid", i), s_valid, tbl[i].sv);
      if (tbl[i].sv) chk($sformatf("vec%0d_s_addr", i), s_addr, tbl[i].sa);
      chk1($sformatf("vec%0d_m0_ready", i), m0_ready, tbl[i].r0);
      chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, tbl[i].d0);
      chk1($sformatf("vec%0d_m1_ready", i), m1_ready, tbl[i].r1);
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].d1);
      chk1($sformatf("vec%0d_err", i), err, 1'b0);
    end
    // fairness: both held from reset, slave ready one cycle after s_valid
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h1000; m1_valid = 1'b1; m1_addr = 32'h2000;
    sv_p = 1'b0; sr_p = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        s_ready = sv_p && !sr_p;
        s_rdata = s_addr ^ 32'hA5A5_0000;
        #2;
        sv_p = s_valid; sr_p = s_ready;
        if (m0_ready || m1_ready) begin
          got = 1'b1;
          fexp = ((k % 2 == 1) ? 32'h2000 : 32'h1000) ^ 32'hA5A5_0000;
          chk1($sformatf("fair%0d_m0_ready", k), m0_ready, k % 2 == 0);
          chk1($sformatf("fair%0d_m1_ready", k), m1_ready, k % 2 == 1);
          chk($sformatf("fair%0d_rdata", k), m0_ready ? m0_rdata : m1_rdata, fexp);
        end
      end
      if (!got) chk1($sformatf("fair%0d_completion_seen", k), 1'b0, 1'b1);
    end
    // watchdog: first address sticks, clear-with-timeout reloads, ready on the last cycle wins
    do_reset();
    run_tmo(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    run_tmo(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    run_tmo(1'b0, 32'h0000_0088, 1'b1, 1'b0, 1'b1, 32'h0000_0088);
    tick();
    err_clr = 1'b1;
    #2 chk1("clr_err_before", err, 1'b1);
    tick();
    err_clr = 1'b0;
    #2;
    chk1("clr_err", err, 1'b0);
    chk("clr_err_addr", err_addr, 32'h0);
    run_tmo(1'b0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'h0);
    run_tmo(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 32'h0000_0099);
    // asynchronous reset while BUSY with the slave answering
    tick();
    m0_valid = 1'b1; m0_addr = 32'h500;
    #2 chk1("ar_idle_sv", s_valid, 1'b0);
    tick();
    #2 chk1("ar_busy_sv", s_valid, 1'b1);
    s_ready = 1'b1; s_rdata = 32'h7777_0000;
    #1 chk1("ar_pre_ready", m0_ready, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("ar_s_valid", s_valid, 1'b0);
    chk1("ar_m0_ready", m0_ready, 1'b0);
    chk("ar_m0_rdata", m0_rdata, 32'h0);
    chk1("ar_m1_ready", m1_ready, 1'b0);
    chk1("ar_err", err, 1'b0);
    chk("ar_err_addr", err_addr, 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    m1_valid = 1'b1; m1_addr = 32'h600; s_ready = 1'b0;
    #2 chk1("ar_rel_sv", s_valid, 1'b0);
    tick();
    #2 chk("ar_first_addr", s_addr, 32'h500);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    #2;
    chk1("ar_m0_done", m0_ready, 1'b1);
    chk("ar_m0_data", m0_rdata, 32'h0BAD_F00D);
    chk1("ar_m1_quiet", m1_ready, 1'b0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    #2 chk1("ar_gap_sv", s_valid, 1'b0);
    tick();
    #2 chk("ar_second_addr", s_addr, 32'h600);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0000_0606;
    #2 chk1("ar_m1_done", m1_ready, 1'b1);
    // randomized traffic against a transaction-level model
    do_reset();
    m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_err = 1'b0; m_eaddr = '0; m_addr = '0; m_wait = 0;
    pend = '0; prev_r = '0; pa[0] = '0; pa[1] = '0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (prev_r[i]) pend[i] = 1'b0;
        else if (pend[i] && $urandom_range(31) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = {$urandom_range(5) == 0, 29'($urandom), 2'b00};
        end
      end
      m0_valid = pend[0]; m0_addr = pa[0]; m1_valid = pend[1]; m1_addr = pa[1];
      s_ready = (m_busy && m_addr[31]) ? 1'b0 : $urandom_range(2) == 0;
      s_rdata = $urandom;
      err_clr = $urandom_range(23) == 0;
      #2;
      e_r = '0; e_d = '0; tmo = 1'b0; fin = 1'b0;
      if (m_busy) begin
        gv = m_own ? m1_valid : m0_valid;
        if (s_ready) begin fin = 1'b1; e_r[m_own] = 1'b1; e_d = s_rdata; end
        else if (!gv) fin = 1'b1;
        else if (m_wait == TMO - 1) begin fin = 1'b1; tmo = 1'b1; e_r[m_own] = 1'b1; e_d = ERR; end
        else m_wait++;
      end
      chk1("rnd_s_valid", s_valid, m_busy);
      if (m_busy) chk("rnd_s_addr", s_addr, m_addr);
      chk1("rnd_m0_ready", m0_ready, e_r[0]);
      chk("rnd_m0_rdata", m0_rdata, e_r[0] ? e_d : 32'h0);
      chk1("rnd_m1_ready", m1_ready, e_r[1]);
      chk("rnd_m1_rdata", m1_rdata, e_r[1] ? e_d : 32'h0);
      chk1("rnd_err", err, m_err);
      chk("rnd_err_addr", err_addr, m_eaddr);
      prev_r = e_r;
      if (tmo) begin
        if (!m_err || err_clr) m_eaddr = m_addr;
        m_err = 1'b1;
      end else if (err_clr) begin
        m_err = 1'b0;
        m_eaddr = '0;
      end
      if (m_busy) begin
        if (fin) m_busy = 1'b0;
      end else if (m0_valid || m1_valid) begin
        m_own = (m0_valid && m1_valid) ? !m_last : m1_valid;
        m_last = m_own;
        m_addr = m_own ? m1_addr : m0_addr;
        m_wait = 0;
        m_busy = 1'b1;
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/progmem_arbiter.md
Name: progmem_arbiter

Overview:
- Shares the single read-only program-memory port (PicoRV32-style valid/ready, registered 1-cycle ready) between two requesters: m0 = CPU instruction/data fetch, m1 = debug/DMA reader.
- Round-robin arbitration; grant held until the slave completes.
- Bus-timeout watchdog completes hung transactions (e.g. addresses outside the memory window that never assert ready) with an error word and a sticky error flag.
- Sits between the core bus decoder and the program memory in the SPI demo SoC.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, read data width.
- TIMEOUT, 16, cycles in BUSY without s_ready before forced completion; legal range 2..255.
- ERR_WORD, 32'hDEAD_BEEF, rdata returned on a timed-out transaction.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m0_valid  in  1  requester 0 request, held until m0_ready
- m0_addr  in  ADDR_W  requester 0 byte address
- m0_ready  out  1  requester 0 completion pulse
- m0_rdata  out  DATA_W  requester 0 read data, valid when m0_ready
- m1_valid / m1_addr / m1_ready / m1_rdata  same as m0, for requester 1
- s_valid  out  1  request to program memory
- s_addr  out  ADDR_W  address to program memory
- s_ready  in  1  program memory completion
- s_rdata  in  DATA_W  program memory data
- err  out  1  sticky timeout flag
- err_addr  out  ADDR_W  address of the first timed-out transaction since the last clear
- err_clr  in  1  clears err and err_addr

Behaviour:
- Reset values: state=IDLE, last_grant=1 (m0 wins first tie), s_valid=0, s_addr=0, m*_ready=0, err=0, err_addr=0, timeout count=0.
- Two states: IDLE and BUSY.
- IDLE:
  - If any m*_valid is asserted, register the grant and the granted address, and go to BUSY next cycle.
  - One requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates at grant time.
- BUSY:
  - s_valid=1 and s_addr = latched address, both registered.
  - The timeout count increments each cycle.
- Completion by s_ready:
  - m<g>_ready = s_ready combinationally, gated by grant and by BUSY.
  - m<g>_rdata = s_rdata.
  - The non-granted requester's ready stays 0.
  - Next state is IDLE; s_valid drops the next cycle.
- Timeout:
  - Triggers when the count reaches TIMEOUT-1 with s_ready=0.
  - m<g>_ready pulses for one cycle with rdata=ERR_WORD.
  - err is set; err_addr captures the latched address only if err was 0.
  - Next state is IDLE.
- Simultaneous s_ready and timeout: s_ready wins; normal data, no error.
- Abort: the granted requester drops valid while BUSY and s_ready=0 → return to IDLE; no ready pulse; no error; s_valid deasserts the next cycle.
- Latency: request seen at cycle t (IDLE) → s_valid at t+1 → progmem ready at t+2 → m_ready at t+2 → IDLE at t+3.
  - Every transaction has at least one IDLE cycle between grants.
  - A requester still holding valid after its completion cycle is treated as a new request.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Simultaneous err_clr and timeout: the set wins; err=1 and err_addr is loaded with the new address.
- m*_rdata is 0 when the corresponding ready is 0.
- Async reset mid-BUSY: everything returns to reset values immediately; no ready pulse is emitted.

Decomposition:
- Shared package `progmem_bus_pkg`:
  - State enum (IDLE, BUSY).
  - ERR_WORD default.
  - PicoRV32 bus request struct (valid, addr) and response struct (ready, rdata).
- One natural sub-module: `rr_arbiter2`.
  - Two-input round-robin grant logic with a last_grant register and an update-enable input.
  - Reusable for the planned data-memory arbiter.
- The timeout counter stays inline.

Test Plan:
- Single m0 read of addr 0x0010_0004, progmem-like slave (ready one cycle after valid, data 0x01000537) → s_valid at t+1, m0_ready and m0_rdata=0x01000537 at t+2, m1_ready stays 0.
- m0 and m1 valid in the same cycle from reset, both held → grant order m0, m1, m0, m1, verified over 8 transactions; each gets the correct data.
- m1 reads addr 0x0000_0000, slave never readies, TIMEOUT=16 → m1_ready pulses at cycle t+16 with 0xDEADBEEF; err=1; err_addr=0x0000_0000. A second timeout at 0x44 leaves err_addr at 0; err_clr then clears both.
- Slave asserts ready exactly in the timeout cycle → normal data returned, err stays 0.
- m0 granted, then drops valid before s_ready → no m0_ready, IDLE next cycle, a pending m1 request is granted immediately after.
- rstn pulled low while BUSY → s_valid, m*_ready, and err are 0 asynchronously. After release, a new m0 request completes normally with m0 having tie priority.
